address_to_index: RTL

//  Inverse of the coprocessor's index-to-address mapping. Takes a word address
//  in coprocessor memory and returns its region, block row/column and element
//  row/column inside the KxK block. Used by the memory-write monitor and the

---
 rtl/address_to_index_if.sv | 40 ++++
 rtl/address_to_index.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/address_to_index_if.sv
// ---------------------------------------------------------------------------
// address_to_index_if
// Purpose: request/response bundle for the address_to_index decoder.
//   Request side : i_Valid / o_Ready handshake carrying i_Address, i_Config
//   Response side: o_Valid / i_Ready handshake carrying o_Type, block
//                  row/column and element row/column.
// Modports:
//   slave  - the decoder (consumes requests, produces results)
//   master - the requester/consumer (testbench, write monitor, debug port)
// Signal names keep the decoder's point of view (i_ = into decoder).
// ---------------------------------------------------------------------------
interface address_to_index_if #(
    parameter int INDEX_WIDTH     = 8,
    parameter int LOG_MEMORY_SIZE = 10,
    parameter int ELEM_WIDTH      = 4
);
    logic                       i_Valid;
    logic                       o_Ready;
    logic [LOG_MEMORY_SIZE-1:0] i_Address;
    logic [31:0]                i_Config;
    logic                       o_Valid;
    logic                       i_Ready;
    logic [2:0]                 o_Type;
    logic [INDEX_WIDTH-1:0]     o_Row_Index;
    logic [INDEX_WIDTH-1:0]     o_Column_Index;
    logic [ELEM_WIDTH-1:0]      o_Elem_Row;
    logic [ELEM_WIDTH-1:0]      o_Elem_Col;

    modport slave (
        input  i_Valid, i_Address, i_Config, i_Ready,
        output o_Ready, o_Valid, o_Type, o_Row_Index, o_Column_Index,
               o_Elem_Row, o_Elem_Col
    );

    modport master (
        output i_Valid, i_Address, i_Config, i_Ready,
        input  o_Ready, o_Valid, o_Type, o_Row_Index, o_Column_Index,
               o_Elem_Row, o_Elem_Col
    );
endinterface

// File: rtl/address_to_index.sv
// ---------------------------------------------------------------------------
// address_to_index
// Purpose: inverse of the coprocessor index-to-address mapping. Decodes a
//   word address into its region (A/B/C/invalid), block row/column and
//   element row/column inside the KxK block. All divisions are done by
//   repeated subtraction in a small FSM, so no divider hardware is built.
// Ports:
//   i_Clk    - clock, rising edge
//   i_Rst_n  - asynchronous reset, active low
//   bus      - address_to_index_if.slave: request handshake (i_Valid/o_Ready,
//              i_Address, i_Config = {8'h-, mu, gamma, lambda}) and result
//              handshake (o_Valid/i_Ready, o_Type, indices)
// ---------------------------------------------------------------------------
module address_to_index #(
    parameter int INDEX_WIDTH     = 8,
    parameter int K               = 4,
    parameter int LOG_MEMORY_SIZE = 10,
    parameter int OUTPUT_START    = 512,
    parameter int ELEM_WIDTH      = 4
) (
    input logic                 i_Clk,
    input logic                 i_Rst_n,
    address_to_index_if.slave   bus
);

    // Region bounds are products of two config fields and K*K; the working
    // width leaves room for that plus the base offset so nothing wraps.
    localparam int KK      = K * K;
    localparam int W_ARITH = 2 * INDEX_WIDTH + $clog2(KK) + 2;
    localparam int W       = (W_ARITH > LOG_MEMORY_SIZE + 1) ? W_ARITH : LOG_MEMORY_SIZE + 1;

    localparam logic [W-1:0] LP_KK     = W'(KK);
    localparam logic [W-1:0] LP_K      = W'(K);
    localparam logic [W-1:0] LP_A_BASE = W'(2);
    localparam logic [W-1:0] LP_OUT    = W'(OUTPUT_START);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLASSIFY,
        S_DIV_BLOCK,
        S_DIV_IDX,
        S_DIV_ELEM,
        S_DONE
    } state_t;

    state_t                     r_State;
    logic [LOG_MEMORY_SIZE-1:0] r_Address;
    logic [7:0]                 r_Mu;
    logic [7:0]                 r_Gamma;
    logic [7:0]                 r_Lambda;
    logic [7:0]                 r_Stride;
    logic [W-1:0]               r_Rel;
    logic [W-1:0]               r_Blk;
    logic                       r_Ready;
    logic                       r_Valid;
    logic [2:0]                 r_Type;
    logic [INDEX_WIDTH-1:0]     r_Row;
    logic [INDEX_WIDTH-1:0]     r_Col;
    logic [ELEM_WIDTH-1:0]      r_ERow;
    logic [ELEM_WIDTH-1:0]      r_ECol;

    logic [W-1:0] w_Addr;
    logic [W-1:0] w_Mu;
    logic [W-1:0] w_Gamma;
    logic [W-1:0] w_Lambda;
    logic [W-1:0] w_Stride;
    logic [W-1:0] w_AEnd;
    logic [W-1:0] w_BEnd;
    logic [W-1:0] w_CEnd;
    logic         w_InA;
    logic         w_InB;
    logic         w_InC;

    assign w_Addr   = W'(r_Address);
    assign w_Mu     = W'(r_Mu);
    assign w_Gamma  = W'(r_Gamma);
    assign w_Lambda = W'(r_Lambda);
    assign w_Stride = W'(r_Stride);

    // Region ends from the latched config; A wins over B wins over C when
    // the ranges overlap, which the if/else chain in CLASSIFY enforces.
    assign w_AEnd = LP_A_BASE + w_Lambda * w_Mu * LP_KK;
    assign w_BEnd = w_AEnd + w_Mu * w_Gamma * LP_KK;
    assign w_CEnd = LP_OUT + w_Lambda * w_Gamma * LP_KK;

    assign w_InA = (w_Addr >= LP_A_BASE) && (w_Addr < w_AEnd);
    assign w_InB = (w_Addr >= w_AEnd)    && (w_Addr < w_BEnd);
    assign w_InC = (w_Addr >= LP_OUT)    && (w_Addr < w_CEnd);

    assign bus.o_Ready        = r_Ready;
    assign bus.o_Valid        = r_Valid;
    assign bus.o_Type         = r_Type;
    assign bus.o_Row_Index    = r_Row;
    assign bus.o_Column_Index = r_Col;
    assign bus.o_Elem_Row     = r_ERow;
    assign bus.o_Elem_Col     = r_ECol;

    // Decode FSM. The result registers double as the quotient accumulators;
    // they are cleared at accept so an invalid address reports all zeros.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            r_State   <= S_IDLE;
            r_Address <= '0;
            r_Mu      <= '0;
            r_Gamma   <= '0;
            r_Lambda  <= '0;
            r_Stride  <= '0;
            r_Rel     <= '0;
            r_Blk     <= '0;
            r_Ready   <= 1'b1;
            r_Valid   <= 1'b0;
            r_Type    <= '0;
            r_Row     <= '0;
            r_Col     <= '0;
            r_ERow    <= '0;
            r_ECol    <= '0;
        end else begin
            case (r_State)
                S_IDLE: begin
                    if (bus.i_Valid) begin
                        r_Address <= bus.i_Address;
                        r_Mu      <= bus.i_Config[23:16];
                        r_Gamma   <= bus.i_Config[15:8];
                        r_Lambda  <= bus.i_Config[7:0];
                        r_Rel     <= '0;
                        r_Blk     <= '0;
                        r_Type    <= '0;
                        r_Row     <= '0;
                        r_Col     <= '0;
                        r_ERow    <= '0;
                        r_ECol    <= '0;
                        r_Ready   <= 1'b0;
                        r_State   <= S_CLASSIFY;
                    end
                end
                S_CLASSIFY: begin
                    if (w_InA) begin
                        r_Type   <= 3'b001;
                        r_Rel    <= w_Addr - LP_A_BASE;
                        r_Stride <= r_Mu;
                        r_State  <= S_DIV_BLOCK;
                    end else if (w_InB) begin
                        r_Type   <= 3'b010;
                        r_Rel    <= w_Addr - w_AEnd;
                        r_Stride <= r_Gamma;
                        r_State  <= S_DIV_BLOCK;
                    end else if (w_InC) begin
                        r_Type   <= 3'b100;
                        r_Rel    <= w_Addr - LP_OUT;
                        r_Stride <= r_Gamma;
                        r_State  <= S_DIV_BLOCK;
                    end else begin
                        r_Type   <= 3'b000;
                        r_Valid  <= 1'b1;
                        r_State  <= S_DONE;
                    end
                end
                S_DIV_BLOCK: begin
                    if (r_Rel >= LP_KK) begin
                        r_Rel <= r_Rel - LP_KK;
                        r_Blk <= r_Blk + W'(1);
                    end else begin
                        r_State <= S_DIV_IDX;
                    end
                end
                // Stride is never zero here: a zero field empties its region.
                S_DIV_IDX: begin
                    if (r_Blk >= w_Stride) begin
                        r_Blk <= r_Blk - w_Stride;
                        r_Row <= r_Row + INDEX_WIDTH'(1);
                    end else begin
                        r_Col   <= r_Blk[INDEX_WIDTH-1:0];
                        r_State <= S_DIV_ELEM;
                    end
                end
                S_DIV_ELEM: begin
                    if (r_Rel >= LP_K) begin
                        r_Rel  <= r_Rel - LP_K;
                        r_ERow <= r_ERow + ELEM_WIDTH'(1);
                    end else begin
                        r_ECol  <= r_Rel[ELEM_WIDTH-1:0];
                        r_Valid <= 1'b1;
                        r_State <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.i_Ready) begin
                        r_Valid <= 1'b0;
                        r_Ready <= 1'b1;
                        r_State <= S_IDLE;
                    end
                end
                default: begin
                    r_Valid <= 1'b0;
                    r_Ready <= 1'b1;
                    r_State <= S_IDLE;
                end
            endcase
        end
    end

endmodule
